lut_lookup_ctrl: RTL and testbench

Shared key→data lookup table with a run-time configuration port, serving NR_REQ requesters. A round-robin arbiter grants one lookup per cycle. The match is computed with the team's key-compare/OR-reduce mux semantics against the registered table, and the result goes to a single-entry output register under valid/ready backpressure. The block sits between decode-side requesters and the table contents programmed by the configuration master.

---
 rtl/lut_ctrl_pkg.sv | 18 +
 rtl/lut_lookup_ctrl_if.sv | 31 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/lut_lookup_ctrl.sv | 135 +++++++++++++
 tb/tb_lut_lookup_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_ctrl_pkg.sv
// Shared definitions for the LUT lookup controller slice.
//   idx_w   : index width helper ($clog2 that never returns 0)
//   key_lo  : low bit of requester n's key inside a packed key bus
//   CNT_W / CNT_MAX : statistics counter width and saturation value
package lut_ctrl_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int key_lo(input int n, input int key_len);
    return n * key_len;
  endfunction

endpackage

// File: rtl/lut_lookup_ctrl_if.sv
// Request/response bus of the LUT lookup controller.
//   req_valid/req_key/req_ready : per-requester lookup handshake (packed keys)
//   rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_hit : single response channel
// master = requester/consumer side, slave = lut_lookup_ctrl.
interface lut_lookup_ctrl_if
  import lut_ctrl_pkg::*;
#(
  parameter int NR_REQ   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  parameter int ID_W     = idx_w(NR_REQ)
);
  logic [NR_REQ-1:0]         req_valid;
  logic [NR_REQ*KEY_LEN-1:0] req_key;
  logic [NR_REQ-1:0]         req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_LEN-1:0]       rsp_data;
  logic                      rsp_hit;

  modport master (
    output req_valid, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_hit
  );

  modport slave (
    input  req_valid, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_hit
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating pointer.
//   req : request vector        en  : allow a grant this cycle
//   adv : move pointer to idx   gnt : one-hot grant, idx : granted index
// Search starts at ptr+1 and wraps; pointer resets to N-1 so req 0 wins first.
module rr_arbiter
  import lut_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (en && !found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      ptr <= IW'(N - 1);
    else if (adv) ptr <= idx;
  end

endmodule

// File: rtl/lut_lookup_ctrl.sv
// Shared key->data lookup table with a configuration port.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : round-robin request handshake + registered response
//   cfg_we/idx/key/data/en : program one table entry at the clock edge
//   cfg_clear         : drop all enables and zero both counters
//   hit_cnt/miss_cnt  : saturating lookup statistics
module lut_lookup_ctrl
  import lut_ctrl_pkg::*;
#(
  parameter int                   NR_REQ       = 4,
  parameter int                   NR_KEY       = 4,
  parameter int                   KEY_LEN      = 4,
  parameter int                   DATA_LEN     = 8,
  parameter logic [DATA_LEN-1:0]  DEFAULT_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  lut_lookup_ctrl_if.slave           bus,
  input  logic                       cfg_we,
  input  logic [idx_w(NR_KEY)-1:0]   cfg_idx,
  input  logic [KEY_LEN-1:0]         cfg_key,
  input  logic [DATA_LEN-1:0]        cfg_data,
  input  logic                       cfg_en,
  input  logic                       cfg_clear,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [CNT_W-1:0]           miss_cnt
);

  localparam int ID_W = idx_w(NR_REQ);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [KEY_LEN-1:0]  tbl_key  [NR_KEY];
  logic [DATA_LEN-1:0] tbl_data [NR_KEY];
  logic [NR_KEY-1:0]   tbl_en;

  logic                slot_free;
  logic [NR_REQ-1:0]   gnt_p0;
  logic [ID_W-1:0]     id_p0;
  logic                grant_p0;
  logic [KEY_LEN-1:0]  key_p0;
  logic                hit_p0;
  logic [DATA_LEN-1:0] data_p0;

  logic                vld_p1;
  logic [ID_W-1:0]     id_p1;
  logic [DATA_LEN-1:0] data_p1;
  logic                hit_p1;

  // ---- stage p0: arbitration and table match ----
  // The arbiter never sees the key, so req_ready is independent of req_key.
  assign slot_free = !vld_p1 || bus.rsp_ready;
  assign grant_p0  = |gnt_p0;

  rr_arbiter #(.N(NR_REQ), .IW(ID_W)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.req_valid),
    .en  (slot_free && !rst),
    .adv (grant_p0),
    .gnt (gnt_p0),
    .idx (id_p0)
  );

  assign bus.req_ready = gnt_p0;
  assign key_p0 = bus.req_key[key_lo(int'(id_p0), KEY_LEN) +: KEY_LEN];

  // Scan from the top down so the lowest matching index overwrites last.
  always_comb begin
    hit_p0  = 1'b0;
    data_p0 = DEFAULT_DATA;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (tbl_en[i] && tbl_key[i] == key_p0) begin
        hit_p0  = 1'b1;
        data_p0 = tbl_data[i];
      end
    end
  end

  // Table write; the lookup above already used the pre-write contents.
  // Clear is applied before the write so a same-cycle write keeps cfg_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_en <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        tbl_key[i]  <= '0;
        tbl_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (cfg_clear) tbl_en[i] <= 1'b0;
        if (cfg_we && int'(cfg_idx) == i) begin
          tbl_key[i]  <= cfg_key;
          tbl_data[i] <= cfg_data;
          tbl_en[i]   <= cfg_en;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_clear) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (grant_p0) begin
      if (hit_p0) hit_cnt  <= sat_inc(hit_cnt);
      else        miss_cnt <= sat_inc(miss_cnt);
    end
  end

  // ---- stage p1: single-entry response register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      data_p1 <= '0;
      hit_p1  <= 1'b0;
    end else if (grant_p0) begin
      vld_p1  <= 1'b1;
      id_p1   <= id_p0;
      data_p1 <= data_p0;
      hit_p1  <= hit_p0;
    end else if (bus.rsp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_id    = id_p1;
  assign bus.rsp_data  = data_p1;
  assign bus.rsp_hit   = hit_p1;

endmodule

// File: tb/tb_lut_lookup_ctrl.sv
// Testbench for lut_lookup_ctrl: directed scenarios plus a randomized run,
// all checked against a behavioural model of the lookup table.
module tb_lut_lookup_ctrl;
  localparam int NR = 4;
  localparam int NK = 4;
  localparam logic [7:0] DEF = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0, cfg_en = 1'b0, cfg_clear = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [3:0] cfg_key = '0;
  logic [7:0] cfg_data = '0;
  logic [15:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  lut_lookup_ctrl_if #(.NR_REQ(NR), .KEY_LEN(4), .DATA_LEN(8)) bus ();

  lut_lookup_ctrl #(.NR_REQ(NR), .NR_KEY(NK), .KEY_LEN(4), .DATA_LEN(8),
                    .DEFAULT_DATA(DEF)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key), .cfg_data(cfg_data),
    .cfg_en(cfg_en), .cfg_clear(cfg_clear),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int         m_ptr;
  logic [3:0] m_key [NK];
  logic [7:0] m_data [NK];
  bit         m_en [NK];
  bit         m_vld;
  int         m_id;
  logic [7:0] m_rdata;
  bit         m_rhit;
  int         m_hc, m_mc;
  logic [NR-1:0] exp_gnt, obs_gnt;

  function automatic logic [3:0] req_key_of(input int n);
    logic [15:0] v;
    v = bus.req_key;
    return v[n*4 +: 4];
  endfunction

  // One clock: sample grant before the edge, then advance the model.
  task automatic tick();
    int g, mi;
    #2;
    g = -1;
    if (!rst && (!m_vld || bus.rsp_ready))
      for (int k = 1; k <= NR; k++)
        if (g < 0 && bus.req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    exp_gnt = (g < 0) ? '0 : NR'(1 << g);
    obs_gnt = bus.req_ready;
    mi = -1;
    if (g >= 0)
      for (int i = 0; i < NK; i++)
        if (mi < 0 && m_en[i] && m_key[i] == req_key_of(g)) mi = i;
    @(posedge clk);
    if (rst) begin
      m_ptr = NR - 1; m_vld = 0; m_id = 0; m_rdata = 0; m_rhit = 0;
      m_hc = 0; m_mc = 0;
      for (int i = 0; i < NK; i++) begin m_key[i] = 0; m_data[i] = 0; m_en[i] = 0; end
    end else begin
      if (g >= 0) begin
        m_vld = 1; m_id = g; m_ptr = g;
        m_rhit = (mi >= 0);
        m_rdata = (mi >= 0) ? m_data[mi] : DEF;
      end else if (bus.rsp_ready) m_vld = 0;
      if (cfg_clear) begin m_hc = 0; m_mc = 0; end
      else if (g >= 0) begin
        if (mi >= 0) m_hc = (m_hc < 65535) ? m_hc + 1 : 65535;
        else         m_mc = (m_mc < 65535) ? m_mc + 1 : 65535;
      end
      if (cfg_clear) for (int i = 0; i < NK; i++) m_en[i] = 0;
      if (cfg_we) begin
        m_key[cfg_idx] = cfg_key; m_data[cfg_idx] = cfg_data; m_en[cfg_idx] = cfg_en;
      end
    end
    #1;
  endtask

  task automatic set_req(input int n, input logic [3:0] k);
    logic [15:0] v;
    v = bus.req_key;
    v[n*4 +: 4] = k;
    bus.req_key = v;
    bus.req_valid[n] = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input logic [3:0] k, input logic [7:0] d, input bit en);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_key = k; cfg_data = d; cfg_en = en;
    tick();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; bus.req_valid = '1; bus.req_key = '0; bus.rsp_ready = 1;
    tick(); tick();
    checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", obs_gnt); end
    rst = 0; bus.req_valid = '0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h00 || bus.rsp_hit !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got id=%0d data=%h hit=%b want 0/00/0", bus.rsp_id, bus.rsp_data, bus.rsp_hit); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_hit();
    cfg_write(0, 4'd3, 8'hA5, 1);
    cfg_write(1, 4'd7, 8'h3C, 1);
    set_req(0, 4'd3);
    tick();
    bus.req_valid = '0;
    checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL hit_gnt got %b want 0001", obs_gnt); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'hA5 || bus.rsp_hit !== 1'b1) begin
      errors++; $display("FAIL hit_rsp got v=%b id=%0d data=%h hit=%b want 1/0/a5/1", bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_hit); end
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
  endtask

  task automatic test_miss();
    set_req(1, 4'd9);
    tick();
    bus.req_valid = '0;
    checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== DEF || bus.rsp_hit !== 1'b0) begin
      errors++; $display("FAIL miss_rsp got id=%0d data=%h hit=%b want 1/00/0", bus.rsp_id, bus.rsp_data, bus.rsp_hit); end
    checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL miss_cnt got %0d want 1", miss_cnt); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_vld got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    for (int n = 0; n < NR; n++) set_req(n, 4'($urandom_range(0, 15)));
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (obs_gnt !== exp_gnt || $countones(obs_gnt) != 1) begin
        errors++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, obs_gnt, exp_gnt); end
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(m_id) || bus.rsp_data !== m_rdata) begin
        errors++; $display("FAIL rr_rsp cycle %0d got v=%b id=%0d data=%h want 1/%0d/%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_id, m_rdata); end
    end
  endtask

  task automatic test_backpressure();
    int h_id; logic [7:0] h_data; bit h_hit;
    tick();
    h_id = m_id; h_data = m_rdata; h_hit = m_rhit;
    bus.rsp_ready = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt cycle %0d got %b want 0000", c, obs_gnt); end
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(h_id) || bus.rsp_data !== h_data || bus.rsp_hit !== h_hit) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b id=%0d data=%h hit=%b want 1/%0d/%h/%b",
                           c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_hit, h_id, h_data, h_hit); end
    end
    bus.rsp_ready = 1;
    tick();
    checks++; if (obs_gnt !== exp_gnt || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((h_id + 1) % NR)) begin
      errors++; $display("FAIL bp_refill got gnt=%b v=%b id=%0d want gnt=%b v=1 id=%0d", obs_gnt, bus.rsp_valid, bus.rsp_id, exp_gnt, (h_id + 1) % NR); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_cfg_same_cycle();
    set_req(0, 4'd3);
    cfg_we = 1; cfg_idx = 0; cfg_key = 4'd3; cfg_data = 8'h11; cfg_en = 1;
    tick();
    cfg_we = 0;
    checks++; if (bus.rsp_data !== 8'hA5 || bus.rsp_hit !== 1'b1) begin
      errors++; $display("FAIL cfg_old got data=%h hit=%b want a5/1", bus.rsp_data, bus.rsp_hit); end
    tick();
    checks++; if (bus.rsp_data !== 8'h11 || bus.rsp_hit !== 1'b1) begin
      errors++; $display("FAIL cfg_new got data=%h hit=%b want 11/1", bus.rsp_data, bus.rsp_hit); end
  endtask

  task automatic test_saturation();
    int mc0;
    mc0 = m_mc;
    for (int c = 0; c < 65540; c++) tick();
    checks++; if (hit_cnt !== 16'hFFFF || m_hc != 65535) begin
      errors++; $display("FAIL sat_hit got %h want ffff", hit_cnt); end
    checks++; if (miss_cnt !== 16'(mc0)) begin errors++; $display("FAIL sat_miss got %0d want %0d", miss_cnt, mc0); end
  endtask

  task automatic test_clear();
    cfg_clear = 1;
    tick();
    cfg_clear = 0;
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    checks++; if (bus.rsp_hit !== 1'b1 || bus.rsp_data !== 8'h11) begin
      errors++; $display("FAIL clr_inflight got hit=%b data=%h want 1/11", bus.rsp_hit, bus.rsp_data); end
    tick();
    checks++; if (bus.rsp_hit !== 1'b0 || bus.rsp_data !== DEF || miss_cnt !== 16'd1) begin
      errors++; $display("FAIL clr_miss got hit=%b data=%h miss=%0d want 0/00/1", bus.rsp_hit, bus.rsp_data, miss_cnt); end
    bus.req_valid = '0;
    cfg_clear = 1; cfg_we = 1; cfg_idx = 1; cfg_key = 4'd7; cfg_data = 8'h3C; cfg_en = 1;
    tick();
    cfg_clear = 0; cfg_we = 0;
    set_req(1, 4'd7);
    tick();
    bus.req_valid = '0;
    checks++; if (bus.rsp_hit !== 1'b1 || bus.rsp_data !== 8'h3C) begin
      errors++; $display("FAIL clr_we got hit=%b data=%h want 1/3c", bus.rsp_hit, bus.rsp_data); end
  endtask

  task automatic test_random();
    logic [3:0] keys [4];
    keys[0] = 4'd3; keys[1] = 4'd7; keys[2] = 4'd9; keys[3] = 4'd12;
    for (int c = 0; c < 300; c++) begin
      bus.req_valid = NR'($urandom_range(0, 15));
      for (int n = 0; n < NR; n++) begin
        logic [15:0] v;
        v = bus.req_key;
        v[n*4 +: 4] = keys[$urandom_range(0, 3)];
        bus.req_key = v;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_idx = 2'($urandom_range(0, 3));
      cfg_key = keys[$urandom_range(0, 3)];
      cfg_data = 8'($urandom);
      cfg_en = ($urandom_range(0, 3) != 0);
      cfg_clear = ($urandom_range(0, 40) == 0);
      tick();
      checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cycle %0d got %b want %b", c, obs_gnt, exp_gnt); end
      checks++; if (bus.rsp_valid !== m_vld || (m_vld && (bus.rsp_id !== 2'(m_id) || bus.rsp_data !== m_rdata || bus.rsp_hit !== m_rhit))) begin
        errors++; $display("FAIL rnd_rsp cycle %0d got v=%b id=%0d data=%h hit=%b want %b/%0d/%h/%b",
                           c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_hit, m_vld, m_id, m_rdata, m_rhit); end
      checks++; if (hit_cnt !== 16'(m_hc) || miss_cnt !== 16'(m_mc)) begin
        errors++; $display("FAIL rnd_cnt cycle %0d got %0d/%0d want %0d/%0d", c, hit_cnt, miss_cnt, m_hc, m_mc); end
    end
    cfg_we = 0; cfg_clear = 0; bus.rsp_ready = 1; bus.req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < NR; n++) set_req(n, 4'd3);
    tick();
    bus.rsp_ready = 0;
    rst = 1;
    tick();
    checks++; if (obs_gnt !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid got gnt=%b v=%b want 0000/0", obs_gnt, bus.rsp_valid); end
    rst = 0; bus.rsp_ready = 1;
    tick();
    checks++; if (obs_gnt !== 4'b0001 || bus.rsp_id !== 2'd0) begin
      errors++; $display("FAIL rstmid_first got gnt=%b id=%0d want 0001/0", obs_gnt, bus.rsp_id); end
    bus.req_valid = '0;
  endtask

  initial begin
    bus.req_valid = '0; bus.req_key = '0; bus.rsp_ready = 1;
    m_ptr = NR - 1; m_vld = 0; m_id = 0; m_rdata = 0; m_rhit = 0; m_hc = 0; m_mc = 0;
    for (int i = 0; i < NK; i++) begin m_key[i] = 0; m_data[i] = 0; m_en[i] = 0; end
    @(negedge clk);
    test_reset();
    test_hit();
    test_miss();
    test_round_robin();
    test_backpressure();
    test_cfg_same_cycle();
    test_saturation();
    test_clear();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
